// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC register, IF/ID slot with valid/ready, redirect and fault handling
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // One past the last fetchable byte; 33 bits so the compare never wraps.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_instr_q, slot_instr_d;
  logic [31:0] slot_pc4_q, slot_pc4_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic        pc_ok;
  logic        slot_free;
  logic        accept;
  logic        load;
  logic        take_redirect;
  logic [31:0] pc_plus4;

  assign pc_plus4      = pc_q + 32'd4;
  assign pc_ok         = ({1'b0, pc_q} < PC_LIMIT);
  assign slot_free     = !valid_q || id_ready;
  assign accept        = valid_q && id_ready;
  assign take_redirect = redirect_valid && (state_q != ST_BOOT);
  assign load          = (state_q == ST_RUN) && slot_free && pc_ok && !take_redirect;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    slot_pc4_d   = slot_pc4_q;
    fault_d      = fault_q;
    count_d      = count_q;

    // A slot consumed by decode counts even if a redirect flushes it the same cycle.
    if (accept) begin
      count_d = count_q + 32'd1;
      valid_d = 1'b0;
    end

    if (take_redirect) begin
      valid_d = 1'b0;
      pc_d    = redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        fault_d = 1'b0;
        state_d = ST_RUN;
      end else begin
        fault_d = 1'b1;
        state_d = ST_FAULT;
      end
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (load) begin
            valid_d      = 1'b1;
            slot_pc_d    = pc_q;
            slot_instr_d = imem_instr;
            slot_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
          end else if (slot_free && !pc_ok) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      slot_pc_q    <= 32'd0;
      slot_instr_q <= 32'd0;
      slot_pc4_q   <= 32'd0;
      fault_q      <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      slot_pc4_q   <= slot_pc4_d;
      fault_q      <= fault_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_pc       = slot_pc_q;
  assign if_instr    = slot_instr_q;
  assign if_pc_plus4 = slot_pc4_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage: boot, stall, redirect, fault, range end, reset
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  assign imem_instr = (imem_addr < 32'h400) ? instr_at(imem_addr) : 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every slot handed to decode is popped here and compared with the bench memory model.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_valid === 1'b1 && id_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pc", if_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", if_pc, e);
        check("sb_instr", if_instr, instr_at(e));
        check("sb_pc4", if_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("rst_count", fetch_count, 32'd0);

    // T1: boot cycle then 0,4,8
    rst_n = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    tick();
    check("boot_valid", {31'd0, if_valid}, 32'd0);
    check("boot_addr", imem_addr, 32'd0);
    tick();
    check("t1_valid", {31'd0, if_valid}, 32'd1);
    check("t1_pc0", if_pc, 32'h0);
    tick();
    check("t1_pc4", if_pc, 32'h4);

    // T2: stall three cycles with slot at 4
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_pc", if_pc, 32'h4);
      check("t2_hold_instr", if_instr, instr_at(32'h4));
      check("t2_hold_addr", imem_addr, 32'h8);
      check("t2_hold_count", fetch_count, 32'd1);
    end
    id_ready = 1'b1;
    tick();
    check("t2_resume_pc", if_pc, 32'h8);
    check("t2_resume_count", fetch_count, 32'd2);
    tick();
    check("t2_next_pc", if_pc, 32'hC);
    check("t2_next_count", fetch_count, 32'd3);

    // T3: redirect during stall flushes slot 0xC
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    check("t3_flush_valid", {31'd0, if_valid}, 32'd0);
    check("t3_addr", imem_addr, 32'h40);
    check("t3_count", fetch_count, 32'd3);
    redirect_valid = 1'b0;
    exp_q.push_back(32'h40);
    tick();
    check("t3_valid", {31'd0, if_valid}, 32'd1);
    check("t3_pc", if_pc, 32'h40);
    check("t3_instr", if_instr, instr_at(32'h40));
    id_ready = 1'b1;
    tick();
    check("t3_count2", fetch_count, 32'd4);

    // T6: redirect with an accepted slot in the same cycle
    exp_q.push_back(32'h44);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    check("t6_count", fetch_count, 32'd5);
    check("t6_flush", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b0;
    exp_q.push_back(32'h80);
    tick();
    check("t6_pc", if_pc, 32'h80);
    check("t6_pc4", if_pc_plus4, 32'h84);

    // T4: misaligned redirect traps, aligned redirect recovers
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    check("t4_fault", {31'd0, fetch_fault}, 32'd1);
    check("t4_valid", {31'd0, if_valid}, 32'd0);
    check("t4_count", fetch_count, 32'd6);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_valid", {31'd0, if_valid}, 32'd0);
      check("t4_hold_fault", {31'd0, fetch_fault}, 32'd1);
      check("t4_hold_addr", imem_addr, 32'h42);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    check("t4_clear", {31'd0, fetch_fault}, 32'd0);
    redirect_valid = 1'b0;
    exp_q.push_back(32'h10);
    tick();
    check("t4_pc", if_pc, 32'h10);
    check("t4_valid2", {31'd0, if_valid}, 32'd1);

    // T5: run off the end of memory
    redirect_valid = 1'b1; redirect_pc = 32'h3F0;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back(32'h3F0); exp_q.push_back(32'h3F4);
    exp_q.push_back(32'h3F8); exp_q.push_back(32'h3FC);
    tick(); tick(); tick(); tick();
    check("t5_last_pc", if_pc, 32'h3FC);
    check("t5_no_fault_yet", {31'd0, fetch_fault}, 32'd0);
    tick();
    check("t5_fault", {31'd0, fetch_fault}, 32'd1);
    check("t5_valid", {31'd0, if_valid}, 32'd0);
    check("t5_addr", imem_addr, 32'h400);
    check("t5_count", fetch_count, 32'd11);
    tick(); tick();
    check("t5_still_idle", {31'd0, if_valid}, 32'd0);

    // Asynchronous reset in the fault state
    rst_n = 1'b0;
    #1;
    check("arst_fault", {31'd0, fetch_fault}, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    check("arst_addr", imem_addr, 32'd0);
    tick();

    // Redirect during BOOT is ignored
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    rst_n = 1'b1;
    tick();
    check("boot_redir_addr", imem_addr, 32'd0);
    redirect_valid = 1'b0;
    exp_q.push_back(32'h0);
    tick();
    check("boot_redir_pc", if_pc, 32'h0);
    tick();
    id_ready = 1'b0;
    tick();
    check("final_count", fetch_count, 32'd1);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
